multdiv_unit: RTL

//  Multi-cycle signed 32-bit multiply/divide unit, directly downstream of the processor's

---
 rtl/multdiv_pkg.sv | 14 +
 rtl/multdiv_counter.sv | 23 ++
 rtl/multdiv_unit.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/multdiv_pkg.sv
// Shared types and defaults for the multiply/divide unit.
package multdiv_pkg;

  localparam int MD_WIDTH = 32;
  localparam int MD_CNT_W = 6;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/multdiv_counter.sv
// Iteration counter with sync clear, enable and terminal-count flag.
module multdiv_counter #(
  parameter int CNT_W = 6,
  parameter int TC    = 32
) (
  input  logic clock,
  input  logic reset,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)     r_cnt <= '0;
    else if (i_clr) r_cnt <= '0;
    else if (i_en)  r_cnt <= r_cnt + CNT_W'(1);
  end

  assign o_tc = (r_cnt == CNT_W'(TC));

endmodule

// File: rtl/multdiv_unit.sv
// Multi-cycle signed multiply (radix-2 Booth) / divide (non-restoring), one step per clock.
module multdiv_unit
  import multdiv_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH,
  parameter int CNT_W = MD_CNT_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY
);

  state_e             r_state;
  // {acc, Q, q-1}; acc carries one guard bit so subtracting an INT_MIN multiplicand cannot wrap
  logic [2*WIDTH+1:0] r_prod;
  logic [WIDTH:0]     r_mcand;
  logic [WIDTH+1:0]   r_rem;
  logic [WIDTH-1:0]   r_quo;
  logic [WIDTH-1:0]   r_dvsr;
  logic               r_neg;
  logic               r_dz;
  logic [WIDTH-1:0]   r_result;
  logic               r_exc;
  logic               r_rdy;

  logic               w_start;
  logic               w_tc;
  logic               w_cnt_en;
  logic [WIDTH:0]     w_acc;
  logic [2*WIDTH+1:0] w_booth_nxt;
  logic [WIDTH-1:0]   w_prod_lo;
  logic [WIDTH-1:0]   w_prod_hi;
  logic               w_mul_ovf;
  logic [WIDTH+1:0]   w_rem_sh;
  logic [WIDTH+1:0]   w_rem_nxt;
  logic [WIDTH-1:0]   w_quo_nxt;
  logic [WIDTH-1:0]   w_quo_fix;
  logic               w_div_ovf;
  logic [WIDTH-1:0]   w_mag_a;
  logic [WIDTH-1:0]   w_mag_b;

  assign w_start  = ctrl_MULT | ctrl_DIV;
  assign w_cnt_en = ((r_state == S_MUL) || (r_state == S_DIV && !r_dz)) && !w_tc;

  multdiv_counter #(.CNT_W(CNT_W), .TC(WIDTH)) u_cnt (
    .clock (clock),
    .reset (reset),
    .i_clr (w_start),
    .i_en  (w_cnt_en),
    .o_tc  (w_tc)
  );

  // Booth step: add/sub multiplicand on {Q0,q-1}, then arithmetic shift right
  always_comb begin
    w_acc = r_prod[2*WIDTH+1:WIDTH+1];
    case (r_prod[1:0])
      2'b01:   w_acc = r_prod[2*WIDTH+1:WIDTH+1] + r_mcand;
      2'b10:   w_acc = r_prod[2*WIDTH+1:WIDTH+1] - r_mcand;
      default: ;
    endcase
  end

  assign w_booth_nxt = {w_acc[WIDTH], w_acc, r_prod[WIDTH:1]};
  assign w_prod_lo   = r_prod[WIDTH:1];
  assign w_prod_hi   = r_prod[2*WIDTH:WIDTH+1];
  assign w_mul_ovf   = (w_prod_hi != {WIDTH{w_prod_lo[WIDTH-1]}});

  // Magnitudes fit unsigned in WIDTH bits (INT_MIN -> 2^(WIDTH-1)); zero-extended in the datapath
  assign w_mag_a = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
  assign w_mag_b = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;

  // Non-restoring step; quotient bit is 1 when the new partial remainder is non-negative
  assign w_rem_sh  = {r_rem[WIDTH:0], r_quo[WIDTH-1]};
  assign w_rem_nxt = r_rem[WIDTH+1] ? (w_rem_sh + {2'b00, r_dvsr})
                                    : (w_rem_sh - {2'b00, r_dvsr});
  assign w_quo_nxt = {r_quo[WIDTH-2:0], ~w_rem_nxt[WIDTH+1]};
  assign w_quo_fix = r_neg ? -r_quo : r_quo;
  assign w_div_ovf = r_quo[WIDTH-1] & ~r_neg;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_prod   <= '0;
      r_mcand  <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_dvsr   <= '0;
      r_neg    <= 1'b0;
      r_dz     <= 1'b0;
      r_result <= '0;
      r_exc    <= 1'b0;
      r_rdy    <= 1'b0;
    end else begin
      r_rdy <= 1'b0;
      if (ctrl_MULT) begin
        r_state <= S_MUL;
        r_prod  <= {{(WIDTH+1){1'b0}}, data_operandB, 1'b0};
        r_mcand <= {data_operandA[WIDTH-1], data_operandA};
      end else if (ctrl_DIV) begin
        r_state <= S_DIV;
        r_rem   <= '0;
        r_quo   <= w_mag_a;
        r_dvsr  <= w_mag_b;
        r_neg   <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
        r_dz    <= (data_operandB == '0);
      end else begin
        case (r_state)
          S_MUL: begin
            if (w_tc) begin
              r_state  <= S_DONE;
              r_result <= w_prod_lo;
              r_exc    <= w_mul_ovf;
              r_rdy    <= 1'b1;
            end else begin
              r_prod <= w_booth_nxt;
            end
          end
          S_DIV: begin
            if (r_dz) begin
              r_state  <= S_DONE;
              r_result <= '0;
              r_exc    <= 1'b1;
              r_rdy    <= 1'b1;
            end else if (w_tc) begin
              r_state  <= S_DONE;
              r_result <= w_quo_fix;
              r_exc    <= w_div_ovf;
              r_rdy    <= 1'b1;
            end else begin
              r_rem <= w_rem_nxt;
              r_quo <= w_quo_nxt;
            end
          end
          S_DONE:  r_state <= S_IDLE;
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign data_result    = r_result;
  assign data_exception = r_exc;
  assign data_resultRDY = r_rdy;

endmodule
